// File: rtl/ddr_wr_arb_pkg.sv
// ddr_wr_arb_pkg
//   Shared types and sizing helpers for the DDR write-burst arbiter.
//   - arb_state_e : scheduler state (IDLE / CMD / DATA)
//   - CMD_LEN_W   : width of the DDR command length field (beats minus one)
//   - SKID_DEPTH  : entries in the write-data skid buffer
//   - byte_shift  : log2 of bytes per data beat, turns a beat offset into a byte offset
//   - offs_width  : width of a per-channel beat offset able to reach FRAME_BEATS
package ddr_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam int CMD_LEN_W  = 8;
  localparam int SKID_DEPTH = 2;

  function automatic int byte_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int offs_width(input int frame_beats);
    return $clog2(frame_beats + 1);
  endfunction

endpackage

// File: rtl/ddr_wr_burst_arb_rr_arb.sv
// rr_arb
//   Combinational round-robin pick. Searches the request vector starting one
//   position after the last granted index, wrapping cyclically.
//   Ports:
//     req_i  [N]          request per channel
//     last_i [clog2(N)]   index granted last time
//     gnt_o  [N]          one-hot grant, zero when nothing requests
module rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o
);

  localparam int IW = $clog2(N);

  logic         found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_wr_burst_arb.sv
// ddr_wr_burst_arb
//   Round-robin scheduler draining N_CH pixel-packing FIFOs into one DDR write
//   port as fixed-length bursts, each at a per-channel frame address.
//   Optional feature macro: DDR_WR_ARB_FLUSH_EN (adds ch_flush for partial bursts).
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     ch_level / ch_base          per-channel FIFO read level / frame base address
//     ch_frame_start              per-channel pulse restarting the frame offset
//     ch_flush (macro only)       per-channel request to drain a partial burst
//     ch_rd_en / ch_rd_data       FIFO read strobe (one-hot) / data one cycle later
//     cmd_valid/ready/addr/len    DDR burst command
//     wd_valid/ready/data/last    DDR write data
//     busy / cur_ch               not idle / granted channel
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | look for a requester, grant round-robin, build command
//   CMD     | cmd_valid held with stable address/length until cmd_ready
//   DATA    | stream exactly the commanded beats through the skid buffer
module ddr_wr_burst_arb
  import ddr_wr_arb_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int LVL_W       = 9,
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 28,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 129600
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*LVL_W-1:0]    ch_level,
  input  logic [N_CH*ADDR_W-1:0]   ch_base,
  input  logic [N_CH-1:0]          ch_frame_start,
`ifdef DDR_WR_ARB_FLUSH_EN
  input  logic [N_CH-1:0]          ch_flush,
`endif
  output logic [N_CH-1:0]          ch_rd_en,
  input  logic [N_CH*DATA_W-1:0]   ch_rd_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [CMD_LEN_W-1:0]     cmd_len,
  output logic                     wd_valid,
  input  logic                     wd_ready,
  output logic [DATA_W-1:0]        wd_data,
  output logic                     wd_last,
  output logic                     busy,
  output logic [$clog2(N_CH)-1:0]  cur_ch
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int BEAT_W = LVL_W;
  localparam int OFFS_W = offs_width(FRAME_BEATS);
  localparam int SHIFT  = byte_shift(DATA_W);

  arb_state_e            state_q, state_d;
  logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]       last_q, last_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [OFFS_W-1:0]     offs_q [N_CH];
  logic [OFFS_W-1:0]     offs_d [N_CH];
  logic [N_CH-1:0]       pend_q, pend_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;
  logic [CMD_LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic [BEAT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [BEAT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_W-1:0]     skid_q [SKID_DEPTH];
  logic [DATA_W-1:0]     skid_d [SKID_DEPTH];

  logic [N_CH-1:0]       full_req, req_sel, gnt;
  logic [CH_W-1:0]       gnt_idx;
  logic [BEAT_W-1:0]     grant_beats;
  logic [OFFS_W-1:0]     offs_eff;
  logic [OFFS_W:0]       offs_sum;
  logic [DATA_W-1:0]     rd_sel;
  logic                  pop, rd_en_c;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      full_req[i] = ch_level[i*LVL_W +: LVL_W] >= LVL_W'(BURST_LEN);
    end
  end

`ifdef DDR_WR_ARB_FLUSH_EN
  logic [N_CH-1:0]   flush_req;
  logic [LVL_W-1:0]  lvl_sel;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      flush_req[i] = !full_req[i] && ch_flush[i] && (ch_level[i*LVL_W +: LVL_W] != '0);
    end
    // Full bursts always win; flush requesters are only arbitrated among themselves.
    req_sel     = (|full_req) ? full_req : flush_req;
    lvl_sel     = ch_level[gnt_idx*LVL_W +: LVL_W];
    grant_beats = (|full_req) ? BEAT_W'(BURST_LEN) : lvl_sel;
  end
`else
  always_comb begin
    req_sel     = full_req;
    grant_beats = BEAT_W'(BURST_LEN);
  end
`endif

  rr_arb #(.N(N_CH)) u_rr_arb (
    .req_i  (req_sel),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) gnt_idx = CH_W'(i);
    end
  end

  // Write data falls through from the FIFO when the skid is empty, so the first
  // beat appears the cycle after the first read.
  always_comb begin
    rd_sel    = ch_rd_data[cur_ch_q*DATA_W +: DATA_W];
    wd_valid  = (occ_q != 2'd0) || inflight_q;
    wd_data   = (occ_q != 2'd0) ? skid_q[0] : (inflight_q ? rd_sel : '0);
    wd_last   = wd_valid && (acc_cnt_q == beats_q - BEAT_W'(1));
    pop       = wd_valid && wd_ready;
    // Count the beat leaving this cycle so a full-rate stream never stalls.
    rd_en_c   = (state_q == ST_DATA) && (rd_cnt_q < beats_q) &&
                ((3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);
    ch_rd_en  = '0;
    if (rd_en_c) ch_rd_en[cur_ch_q] = 1'b1;
    offs_eff  = ch_frame_start[gnt_idx] ? '0 : offs_q[gnt_idx];
    offs_sum  = {1'b0, offs_q[cur_ch_q]} + (OFFS_W+1)'(beats_q);
  end

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    last_d      = last_q;
    beats_d     = beats_q;
    offs_d      = offs_q;
    pend_d      = pend_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    rd_cnt_d    = rd_cnt_q + BEAT_W'(rd_en_c);
    acc_cnt_d   = acc_cnt_q + BEAT_W'(pop);
    inflight_d  = rd_en_c;
    occ_d       = occ_q;
    skid_d      = skid_q;

    case (occ_q)
      2'd0: begin
        if (inflight_q && !pop) begin
          skid_d[0] = rd_sel;
          occ_d     = 2'd1;
        end
      end
      2'd1: begin
        if (pop && inflight_q) begin
          skid_d[0] = rd_sel;
        end else if (pop) begin
          occ_d = 2'd0;
        end else if (inflight_q) begin
          skid_d[1] = rd_sel;
          occ_d     = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          skid_d[0] = skid_q[1];
          if (inflight_q) skid_d[1] = rd_sel;
          else            occ_d     = 2'd1;
        end
      end
    endcase

    // A restart for the channel being served is deferred to the end of its burst.
    for (int i = 0; i < N_CH; i++) begin
      if (ch_frame_start[i]) begin
        if (state_q != ST_IDLE && cur_ch_q == CH_W'(i)) pend_d[i] = 1'b1;
        else                                           offs_d[i] = '0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (|req_sel) begin
          state_d     = ST_CMD;
          cur_ch_d    = gnt_idx;
          beats_d     = grant_beats;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = ch_base[gnt_idx*ADDR_W +: ADDR_W] + (ADDR_W'(offs_eff) << SHIFT);
          cmd_len_d   = CMD_LEN_W'(grant_beats - BEAT_W'(1));
          rd_cnt_d    = '0;
          acc_cnt_d   = '0;
        end
      end
      ST_CMD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pop && wd_last) begin
          state_d = ST_IDLE;
          last_d  = cur_ch_q;
          if (pend_q[cur_ch_q] || ch_frame_start[cur_ch_q])
            offs_d[cur_ch_q] = '0;
          else if (offs_sum >= (OFFS_W+1)'(FRAME_BEATS))
            offs_d[cur_ch_q] = '0;
          else
            offs_d[cur_ch_q] = offs_sum[OFFS_W-1:0];
          pend_d[cur_ch_q] = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= '0;
      last_q      <= CH_W'(N_CH - 1);
      beats_q     <= '0;
      pend_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      rd_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      for (int i = 0; i < N_CH; i++) offs_q[i] <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      last_q      <= last_d;
      beats_q     <= beats_d;
      pend_q      <= pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      rd_cnt_q    <= rd_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      offs_q      <= offs_d;
      skid_q      <= skid_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign busy      = (state_q != ST_IDLE);
  assign cur_ch    = cur_ch_q;

endmodule

// File: tb/tb_ddr_wr_burst_arb.sv
// tb_ddr_wr_burst_arb
//   Directed bench for ddr_wr_burst_arb with 4 channels and a 32-beat frame so
//   address wrap is reachable. FIFOs are modelled as counters: each word is
//   {channel, sequence number}, level = words added - words read.
module tb_ddr_wr_burst_arb;

  logic          clk = 1'b0;
  logic          rst;
  logic [35:0]   ch_level;
  logic [111:0]  ch_base;
  logic [3:0]    ch_frame_start;
`ifdef DDR_WR_ARB_FLUSH_EN
  logic [3:0]    ch_flush;
`endif
  logic [3:0]    ch_rd_en;
  logic [1023:0] ch_rd_data;
  logic          cmd_valid, cmd_ready;
  logic [27:0]   cmd_addr;
  logic [7:0]    cmd_len;
  logic          wd_valid, wd_ready;
  logic [255:0]  wd_data;
  logic          wd_last;
  logic          busy;
  logic [1:0]    cur_ch;

  ddr_wr_burst_arb #(
    .N_CH(4), .LVL_W(9), .DATA_W(256), .ADDR_W(28), .BURST_LEN(16), .FRAME_BEATS(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_level       (ch_level),
    .ch_base        (ch_base),
    .ch_frame_start (ch_frame_start),
`ifdef DDR_WR_ARB_FLUSH_EN
    .ch_flush       (ch_flush),
`endif
    .ch_rd_en       (ch_rd_en),
    .ch_rd_data     (ch_rd_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wd_valid       (wd_valid),
    .wd_ready       (wd_ready),
    .wd_data        (wd_data),
    .wd_last        (wd_last),
    .busy           (busy),
    .cur_ch         (cur_ch)
  );

  always #5 clk = ~clk;

  // FIFO model
  int          avail [4] = '{default: 0};
  int          taken [4] = '{default: 0};
  logic [31:0] fifo_q [4] = '{default: 32'h0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_level[i*9 +: 9]        = 9'(avail[i] - taken[i]);
      ch_rd_data[i*256 +: 256]  = {224'b0, fifo_q[i]};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ch_rd_en[i]) begin
        fifo_q[i] <= {8'(i), 24'(taken[i])};
        taken[i]  <= taken[i] + 1;
      end
    end
  end

  // Monitor: logs handshakes and protocol observations at the falling edge.
  int          cmd_n = 0, beat_n = 0, busy_cyc = 0;
  int          out_cnt = 0, max_out = 0, onehot_err = 0, hold_err = 0;
  logic [27:0] cmd_addr_log [64];
  logic [7:0]  cmd_len_log  [64];
  logic [1:0]  cmd_ch_log   [64];
  logic [31:0] beat_data_log [512];
  logic        beat_last_log [512];
  logic        pv_valid = 1'b0, pv_ready = 1'b0;
  logic [27:0] pv_addr = '0;
  logic [7:0]  pv_len = '0;

  always @(negedge clk) begin
    if (busy) busy_cyc <= busy_cyc + 1;
    if (cmd_valid && cmd_ready && cmd_n < 64) begin
      cmd_addr_log[cmd_n] <= cmd_addr;
      cmd_len_log[cmd_n]  <= cmd_len;
      cmd_ch_log[cmd_n]   <= cur_ch;
      cmd_n               <= cmd_n + 1;
    end
    if (wd_valid && wd_ready && beat_n < 512) begin
      beat_data_log[beat_n] <= wd_data[31:0];
      beat_last_log[beat_n] <= wd_last;
      beat_n                <= beat_n + 1;
    end
    if (ch_rd_en != 4'b0 && ch_rd_en != (4'b0001 << cur_ch)) onehot_err <= onehot_err + 1;
    if (rst) out_cnt <= 0;
    else     out_cnt <= out_cnt + int'(|ch_rd_en) - int'(wd_valid && wd_ready);
    if (out_cnt > max_out) max_out <= out_cnt;
    if (!rst && pv_valid && !pv_ready && (!cmd_valid || cmd_addr != pv_addr || cmd_len != pv_len))
      hold_err <= hold_err + 1;
    pv_valid <= cmd_valid;
    pv_ready <= cmd_ready;
    pv_addr  <= cmd_addr;
    pv_len   <= cmd_len;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int ch, input int n);
    avail[ch] = avail[ch] + n;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (cmd_n >= target && !busy) done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 256'd0, 256'd1);
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (beat_n >= target) done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 256'd0, 256'd1);
  endtask

  // seq0 < 0 skips the per-beat data comparison.
  task automatic chk_burst(input string tag, input int ci, input int bi, input logic [1:0] ch,
                           input logic [27:0] addr, input logic [7:0] len, input int nb,
                           input int seq0);
    int derr;
    int nlast;
    derr  = 0;
    nlast = 0;
    chk({tag, "_addr"}, cmd_addr_log[ci], addr);
    chk({tag, "_len"},  cmd_len_log[ci], len);
    chk({tag, "_ch"},   cmd_ch_log[ci], ch);
    for (int k = 0; k < nb; k++) begin
      if (seq0 >= 0 && beat_data_log[bi+k] !== {8'(ch), 24'(seq0 + k)}) derr++;
      if (beat_last_log[bi+k]) nlast++;
    end
    if (seq0 >= 0) chk({tag, "_data_errs"}, derr, 0);
    chk({tag, "_last_pos"}, beat_last_log[bi+nb-1], 1'b1);
    chk({tag, "_last_cnt"}, nlast, 1);
  endtask

  localparam logic [27:0] B0 = 28'h010_0000;
  localparam logic [27:0] B1 = 28'h020_0000;
  localparam logic [27:0] B2 = 28'h030_0000;
  localparam logic [27:0] B3 = 28'h040_0000;

  int c0, bt0, bc0;
  logic [1:0]  exp_ch   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [27:0] exp_addr [5] = '{B0, B1, B2, B3, B0 + 28'd512};
  int          exp_seq  [5] = '{0, 0, 0, 0, 16};

  initial begin
    rst            = 1'b1;
    cmd_ready      = 1'b1;
    wd_ready       = 1'b1;
    ch_frame_start = 4'b0;
`ifdef DDR_WR_ARB_FLUSH_EN
    ch_flush       = 4'b0;
`endif
    ch_base        = {B3, B2, B1, B0};
    repeat (3) step();

    // reset state
    @(negedge clk);
    chk("rst_ctrl", {busy, cmd_valid, wd_valid, wd_last, ch_rd_en, cur_ch, cmd_len}, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_wdata", wd_data, 0);
    step();
    rst = 1'b0;

    // all channels requesting: round robin from channel 0, ch0 second burst at +512
    c0 = cmd_n; bt0 = beat_n;
    fill(0, 32); fill(1, 16); fill(2, 16); fill(3, 16);
    wait_done("rr", c0 + 5, 400);
    chk("rr_beats", beat_n - bt0, 80);
    for (int k = 0; k < 5; k++)
      chk_burst($sformatf("rr%0d", k), c0 + k, bt0 + 16*k, exp_ch[k], exp_addr[k], 8'd15, 16, exp_seq[k]);

    // single channel 1 burst with cycle-exact timing
    step();
    c0 = cmd_n; bt0 = beat_n; bc0 = busy_cyc;
    fill(1, 16);
    @(negedge clk);
    chk("t1_idle_busy", busy, 1'b0);
    @(negedge clk);
    chk("t1_cmd_valid", cmd_valid, 1'b1);
    chk("t1_cmd_addr", cmd_addr, B1 + 28'd512);
    chk("t1_cmd_len", cmd_len, 8'd15);
    @(negedge clk);
    chk("t1_first_rd", {ch_rd_en, wd_valid}, {4'b0010, 1'b0});
    @(negedge clk);
    chk("t1_first_wd", {wd_valid, wd_data[31:0]}, {1'b1, 8'd1, 24'd16});
    wait_done("t1", c0 + 1, 100);
    chk("t1_busy_cycles", busy_cyc - bc0, 18);
    chk("t1_beats", beat_n - bt0, 16);
    chk_burst("t1", c0, bt0, 2'd1, B1 + 28'd512, 8'd15, 16, 16);

    // third channel 0 burst wraps back to frame base
    step();
    c0 = cmd_n; bt0 = beat_n;
    fill(0, 16);
    wait_done("wrap", c0 + 1, 100);
    chk_burst("wrap", c0, bt0, 2'd0, B0, 8'd15, 16, 32);

    // delayed cmd_ready and random write backpressure on channel 2
    step();
    c0 = cmd_n; bt0 = beat_n;
    cmd_ready = 1'b0;
    fill(2, 16);
    repeat (6) step();
    @(negedge clk);
    chk("bp_cmd_held", {cmd_valid, busy, cmd_addr}, {1'b1, 1'b1, B2 + 28'd512});
    step();
    cmd_ready = 1'b1;
    begin
      bit done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
        step();
        wd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (cmd_n >= c0 + 1 && !busy) done = 1'b1;
      end
      if (!done) chk("bp_timeout", 256'd0, 256'd1);
    end
    wd_ready = 1'b1;
    chk("bp_beats", beat_n - bt0, 16);
    chk_burst("bp", c0, bt0, 2'd2, B2 + 28'd512, 8'd15, 16, 16);
    chk("bp_skid_bound", max_out <= 2, 1'b1);
    chk("bp_cmd_hold_errs", hold_err, 0);

    // frame restart while idle: channel 3 back to base
    step();
    ch_frame_start = 4'b1000;
    step();
    ch_frame_start = 4'b0000;
    c0 = cmd_n; bt0 = beat_n;
    fill(3, 16);
    wait_done("fs_idle", c0 + 1, 100);
    chk_burst("fs_idle", c0, bt0, 2'd3, B3, 8'd15, 16, 16);

    // frame restart mid-burst on channel 1: next burst returns to base instead of +512
    step();
    c0 = cmd_n; bt0 = beat_n;
    fill(1, 16);
    wait_beats("fs_mid", bt0 + 4, 100);
    step();
    ch_frame_start = 4'b0010;
    step();
    ch_frame_start = 4'b0000;
    wait_done("fs_mid", c0 + 1, 100);
    chk_burst("fs_mid", c0, bt0, 2'd1, B1, 8'd15, 16, 32);
    step();
    c0 = cmd_n; bt0 = beat_n;
    fill(1, 16);
    wait_done("fs_next", c0 + 1, 100);
    chk_burst("fs_next", c0, bt0, 2'd1, B1, 8'd15, 16, 48);

    // reset in DATA: outputs clear next cycle, channel 0 offset returns to base
    step();
    c0 = cmd_n;
    fill(0, 16);
    wait_beats("rst_data", beat_n + 3, 100);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstd_ctrl", {busy, cmd_valid, wd_valid, wd_last, ch_rd_en, cur_ch, cmd_len}, 0);
    chk("rstd_addr", cmd_addr, 0);
    chk("rstd_wdata", wd_data, 0);
    step();
    c0 = cmd_n; bt0 = beat_n;
    fill(0, 16);
    wait_done("post_rst", c0 + 1, 100);
    chk("post_rst_beats", beat_n - bt0, 16);
    chk_burst("post_rst", c0, bt0, 2'd0, B0, 8'd15, 16, -1);

`ifdef DDR_WR_ARB_FLUSH_EN
    // partial burst of 5 on channel 2, then a full burst at base + 5 beats
    step();
    c0 = cmd_n; bt0 = beat_n;
    fill(2, 5);
    ch_flush = 4'b0100;
    wait_done("flush", c0 + 1, 100);
    ch_flush = 4'b0000;
    chk("flush_beats", beat_n - bt0, 5);
    chk_burst("flush", c0, bt0, 2'd2, B2, 8'd4, 5, 32);
    step();
    c0 = cmd_n; bt0 = beat_n;
    fill(2, 16);
    wait_done("flush_next", c0 + 1, 100);
    chk_burst("flush_next", c0, bt0, 2'd2, B2 + 28'd160, 8'd15, 16, 37);
`endif

    repeat (3) step();
    chk("rd_en_onehot_errs", onehot_err, 0);
    chk("cmd_hold_errs", hold_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst_arb.md
# ddr_wr_burst_arb

Round-robin scheduler that drains N_CH pixel-packing FIFOs (16-bit write side, 256-bit read side) into a single DDR write port as fixed-length bursts. Sits between the per-channel FIFOs' read side and the DDR write command/data interface. It watches each FIFO's read water level, grants one channel at a time, issues a burst command with a per-channel frame address, then streams exactly the commanded beats. All logic runs in the DDR user clock domain.

## Interface
- N_CH, 4: number of channels/FIFOs (2..8)
- LVL_W, 9: width of each FIFO's rd_water_level
- DATA_W, 256: FIFO read / DDR write data width
- ADDR_W, 28: DDR byte-address width
- BURST_LEN, 16: beats per full burst (power of 2, ≤ 2^(LVL_W-1))
- FRAME_BEATS, 129600: beats per frame per channel; a multiple of BURST_LEN
---
- clk  in  1  DDR user clock; all ports synchronous to it
- rst  in  1  **synchronous, active-high** reset
- ch_level  in  N_CH*LVL_W  per-channel FIFO rd_water_level
- ch_base  in  N_CH*ADDR_W  per-channel frame base byte address; sampled at command issue
- ch_frame_start  in  N_CH  one-cycle pulse: restart channel address at base
- ch_rd_en  out  N_CH  FIFO rd_en, one-hot or zero
- ch_rd_data  in  N_CH*DATA_W  FIFO rd_data, valid one cycle after rd_en
- cmd_valid / cmd_ready  out/in  1  burst command handshake
- cmd_addr  out  ADDR_W  burst start byte address
- cmd_len  out  8  beats minus one
- wd_valid / wd_ready  out/in  1  write-data handshake
- wd_data  out  DATA_W  write beat
- wd_last  out  1  final beat of burst
- busy  out  1  state ≠ IDLE
- cur_ch  out  clog2(N_CH)  granted channel

## Operation
- States: IDLE → CMD → DATA → IDLE.
- IDLE: request[i] = ch_level[i] ≥ BURST_LEN. If any request, grant the first requester searching from last_grant+1 cyclically; latch cur_ch, beats = BURST_LEN; go CMD. After reset, last_grant = N_CH-1 (channel 0 has priority first).
- CMD: cmd_valid=1, cmd_addr = ch_base[cur_ch] + (offset[cur_ch] << log2(DATA_W/8)), cmd_len = beats-1. Hold all values stable until cmd_ready; then go DATA.
- DATA: 2-entry skid buffer. Assert ch_rd_en[cur_ch] when reads issued < beats and (skid occupancy + read in flight) < 2. Data captured into skid the cycle after rd_en. wd_valid = skid non-empty; wd_last on the beat whose accepted count = beats-1. On accepting last beat: offset[cur_ch] += beats, wrap to 0 when it reaches FRAME_BEATS; last_grant = cur_ch; go IDLE.
- ch_frame_start[i] clears offset[i] immediately if i is not in flight; if in flight, a pending flag clears it at burst end instead of incrementing.
- Never read a FIFO beyond the beats granted; level check guarantees no underflow.
- Reset: state IDLE, all offsets 0, skid empty, pending flags 0; every output 0 (cmd_len 0, cur_ch 0).

## Timing
- IDLE→CMD: 1 cycle after request seen; cmd_valid registered.
- First rd_en in the cycle DATA is entered; first wd_valid one cycle later.
- With wd_ready held high: one beat per cycle; burst occupies BURST_LEN+1 DATA cycles; 1 idle cycle between bursts.
- wd_ready low: rd_en stops within the same cycle once skid would overflow; no beat lost or duplicated.

## Configuration
- DDR_WR_ARB_FLUSH_EN defined: extra input ch_flush [N_CH]. In IDLE, a channel with no full-burst request but ch_flush[i]=1 and ch_level[i] > 0 requests a partial burst; beats = ch_level[i] latched at grant; full-burst requesters take priority over flush requesters. Offset advances by beats; wrap rule unchanged.
- Undefined: port absent, only full BURST_LEN bursts issued.

## Structure
- Package ddr_wr_arb_pkg: state enum, burst-length/offset width constants, byte-shift constant log2(DATA_W/8).
- One sub-module: rr_arb (N_CH-wide round-robin pick, combinational request/last-grant in, one-hot grant out).

## Test plan
- Ch1 level=16, others 0, readies high → cmd_addr=base1, cmd_len=15, 16 beats, wd_last on beat 16, offset1=16.
- All channels level ≥16 continuously → grant order 0,1,2,3,0; each cmd_addr advances by 512 bytes per own burst.
- wd_ready toggled 1-0 pseudo-randomly → data matches FIFO order, exactly 16 beats, ≤2 outstanding skid entries.
- FRAME_BEATS=32 ch0: three bursts → addresses base, base+512, base (wrap).
- ch_frame_start[0] mid-burst at offset 16 → next ch0 cmd_addr = base0; rst asserted in DATA → next cycle all outputs 0, state IDLE.
- Flush build: ch2 level=5, ch_flush[2]=1 → cmd_len=4, 5 beats, offset2=5.
